// File: rtl/demux8_collector_pkg.sv
// Shared types and defaults for the bit-scatter / word-assembly collector.
// Holds the collector state encoding and the default word width.
package demux_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } collector_state_t;

    localparam int N_DEFAULT = 8;

endpackage

// File: rtl/demux8_collector_decoder.sv
// Combinational S->N one-hot decoder with enable; indices >= N decode to all-zero.
// Zero latency, no backpressure (pure combinational).
module decoder_n #(
    parameter int N = 8,
    parameter int S = (N > 1) ? $clog2(N) : 1
) (
    input  logic [S-1:0] s,
    input  logic         en,
    output logic [N-1:0] y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < N; i++) begin
            if (en && (int'(s) == i)) begin
                y[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux8_collector.sv
// Registered bit demultiplexer: scatters d into word[s], hands the word out once every position is filled.
// Completion is visible one cycle after the last accept; FULL blocks input until out_ready is seen.
module demux8_collector
    import demux_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int S = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         d,
    input  logic [S-1:0] s,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] sel_onehot,
    output logic         dup,
    output logic         bad_sel,
    output logic [N-1:0] out_word,
    output logic         out_valid,
    input  logic         out_ready
);

    collector_state_t r_state;
    logic [N-1:0]     r_word;
    logic [N-1:0]     r_filled;
    logic             r_dup;
    logic             r_bad_sel;

    logic             w_accept;
    logic             w_sel_ok;
    logic [N-1:0]     w_onehot;
    logic [N-1:0]     w_filled_next;

    assign in_ready  = (r_state == FILL);
    assign out_valid = (r_state == FULL);
    assign w_accept  = in_valid && in_ready;
    assign w_sel_ok  = (int'(s) < N);

    // One decoder serves both the external strobe and the internal write enable.
    decoder_n #(
        .N (N),
        .S (S)
    ) u_decoder (
        .s  (s),
        .en (w_accept),
        .y  (w_onehot)
    );

    assign sel_onehot    = w_onehot;
    assign w_filled_next = r_filled | w_onehot;

    assign out_word = r_word;
    assign dup      = r_dup;
    assign bad_sel  = r_bad_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FILL;
            r_word    <= '0;
            r_filled  <= '0;
            r_dup     <= 1'b0;
            r_bad_sel <= 1'b0;
        end else begin
            r_dup     <= 1'b0;
            r_bad_sel <= 1'b0;
            if (r_state == FILL) begin
                if (w_accept) begin
                    if (w_sel_ok) begin
                        r_word   <= (r_word & ~w_onehot) | (d ? w_onehot : '0);
                        r_filled <= w_filled_next;
                        r_dup    <= |(r_filled & w_onehot);
                        // Mask-based completion: rewriting a position never advances it.
                        if (&w_filled_next) begin
                            r_state <= FULL;
                        end
                    end else begin
                        r_bad_sel <= 1'b1;
                    end
                end
            end else begin
                if (out_ready) begin
                    r_state  <= FILL;
                    r_filled <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux8_collector.sv
// Scoreboard bench for demux8_collector: directed scenarios plus randomized scatter traffic.
// A high-level model predicts completed words and dup pulses; a monitor checks every cycle.
module tb_demux8_collector;

    logic       clk;
    logic       rst_n;
    logic       d;
    logic [2:0] s;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] sel_onehot;
    logic       dup;
    logic       bad_sel;
    logic [7:0] out_word;
    logic       out_valid;
    logic       out_ready;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: a captured bit per position and a set of written positions.
    bit         m_word   [8];
    bit         m_filled [8];
    logic [7:0] word_q[$];
    bit         dup_q[$];
    bit         rand_rdy = 0;

    demux8_collector #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (d),
        .s          (s),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel_onehot (sel_onehot),
        .dup        (dup),
        .bad_sel    (bad_sel),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) begin
            m_word[i]   = 0;
            m_filled[i] = 0;
        end
        word_q.delete();
        dup_q.delete();
    endfunction

    function automatic void model_accept(input bit dv, input int idx);
        int         count;
        logic [7:0] w;
        dup_q.push_back(m_filled[idx]);
        m_word[idx]   = dv;
        m_filled[idx] = 1;
        count = 0;
        for (int i = 0; i < 8; i++) count += m_filled[i];
        if (count == 8) begin
            for (int i = 0; i < 8; i++) begin
                w[i]        = m_word[i];
                m_filled[i] = 0;
            end
            word_q.push_back(w);
        end
    endfunction

    // Starts and ends at posedge+1.
    task automatic send(input logic dv, input logic [2:0] sv);
        in_valid = 1;
        d        = dv;
        s        = sv;
        @(negedge clk);
        if (in_ready && rst_n) model_accept(dv, int'(sv));
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    // Monitor: checks handshake rules, strobe, pulses and word handoff against the model.
    initial begin
        bit         prev_acc  = 0;
        bit         prev_hold = 0;
        logic [7:0] prev_word = '0;
        logic [7:0] exp_sel;
        logic [7:0] exp_word;
        bit         exp_dup;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_acc  = 0;
                prev_hold = 0;
                continue;
            end
            check("in_ready_vs_out_valid", in_ready, !out_valid);
            exp_sel = (in_valid && in_ready) ? (8'd1 << s) : 8'd0;
            check("sel_onehot", sel_onehot, exp_sel);
            check("bad_sel_never", bad_sel, 0);
            if (prev_acc) begin
                if (dup_q.size() == 0) begin
                    check("dup_q_underflow", 1, 0);
                end else begin
                    exp_dup = dup_q.pop_front();
                    check("dup_pulse", dup, exp_dup);
                end
            end else begin
                check("dup_idle", dup, 0);
            end
            if (prev_hold && out_valid) check("out_word_stable", out_word, prev_word);
            if (out_valid && out_ready) begin
                if (word_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    exp_word = word_q.pop_front();
                    check("handoff_word", out_word, exp_word);
                end
            end
            prev_acc  = in_valid && in_ready;
            prev_hold = out_valid && !out_ready;
            prev_word = out_word;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (rand_rdy) begin
                #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        int         waited;
        pat       = 8'h4D;
        rst_n     = 0;
        in_valid  = 0;
        d         = 0;
        s         = 0;
        out_ready = 0;
        model_clear();

        // Reset state
        #12;
        check("reset_out_valid", out_valid, 0);
        check("reset_dup", dup, 0);
        #10;
        rst_n = 1;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", in_ready, 1);
        check("post_reset_out_word", out_word, 8'h00);

        // Strobe in FILL, then with in_valid low
        in_valid = 1;
        s        = 3'd5;
        #1;
        check("strobe_fill_s5", sel_onehot, 8'h20);
        in_valid = 0;
        #1;
        check("strobe_idle", sel_onehot, 8'h00);
        @(posedge clk);
        #1;

        // Fill pattern 0x4D
        for (int i = 0; i < 8; i++) begin
            send(pat[i], 3'(i));
            if (i < 7) check("no_early_valid", out_valid, 0);
        end
        check("fill_out_valid", out_valid, 1);
        check("fill_out_word", out_word, 8'h4D);
        check("fill_in_ready", in_ready, 0);

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_word", out_word, 8'h4D);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        in_valid = 1;
        s        = 3'd5;
        #1;
        check("strobe_full", sel_onehot, 8'h00);
        in_valid  = 0;
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        check("handoff_out_valid", out_valid, 0);
        check("handoff_in_ready", in_ready, 1);

        // Duplicate write
        send(1'b1, 3'd3);
        check("first_write_no_dup", dup, 0);
        send(1'b0, 3'd3);
        check("dup_after_rewrite", dup, 1);
        foreach (pat[i]) begin
            if (i != 3 && i != 7) send(1'($urandom_range(0, 1)), 3'(i));
        end
        check("dup_no_early_valid", out_valid, 0);
        send(1'($urandom_range(0, 1)), 3'd7);
        check("dup_fill_valid", out_valid, 1);
        check("dup_bit3_last_wins", out_word[3], 0);
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;

        // Reset mid-fill
        for (int i = 0; i < 4; i++) send(1'b1, 3'(i));
        #2;
        rst_n = 0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_dup", dup, 0);
        model_clear();
        @(negedge clk);
        #2;
        rst_n = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send(1'b0, 3'(i));
        check("midreset_valid", out_valid, 1);
        check("midreset_word", out_word, 8'h00);
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;

        // Randomized scatter traffic with random consumer backpressure
        rand_rdy = 1;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            end
        end
        rand_rdy = 0;
        @(posedge clk);
        #1;
        out_ready = 1;
        waited = 0;
        while (word_q.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        check("drain_scoreboard_empty", word_q.size(), 0);
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
